// File: rtl/timestamp_pkg.sv
// Shared definitions for the timestamp capture path.
// Holds the default timestamp width and the output stage state type.
package timestamp_pkg;

    localparam int TIMESTAMP_WIDTH_DEF = 64;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

endpackage : timestamp_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at a registered pointer.
// Ports: clk, rst_n, req[N-1:0], advance -> gnt_valid, gnt_idx.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;

    // First requester found walking upward from ptr, wrapping at N.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!gnt_valid && req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && gnt_valid) begin
            ptr <= W'((int'(gnt_idx) + 1) % N);
        end
    end

endmodule : rr_arbiter

// File: rtl/timestamp_capture_arbiter.sv
// Per-channel timestamp capture with round-robin serialisation and drop flags.
// Ports: clk, rst_n, timestamp, trig, enable, out_* handshake, overflow, overflow_clr, drop_count.
module timestamp_capture_arbiter
    import timestamp_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int CH_ID_WIDTH     = 2,
    parameter int TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
    input  logic [NUM_CH-1:0]          trig,
    input  logic [NUM_CH-1:0]          enable,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TIMESTAMP_WIDTH-1:0] out_timestamp,
    output logic [CH_ID_WIDTH-1:0]     out_channel,
    output logic [NUM_CH-1:0]          overflow,
    input  logic                       overflow_clr,
    output logic [15:0]                drop_count
);

    out_state_e state, state_n;

    logic [TIMESTAMP_WIDTH-1:0] hold [NUM_CH];
    logic [NUM_CH-1:0]          pending;
    logic [NUM_CH-1:0]          pending_n;
    logic [NUM_CH-1:0]          cap_req;
    logic [NUM_CH-1:0]          granted;
    logic [NUM_CH-1:0]          capture;
    logic [NUM_CH-1:0]          drop;

    logic                   gnt_valid;
    logic [CH_ID_WIDTH-1:0] gnt_idx;
    logic                   ld;

    logic [4:0]  ndrop;
    logic [16:0] drop_sum;
    logic [15:0] drop_count_n;

    rr_arbiter #(
        .N (NUM_CH),
        .W (CH_ID_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (pending),
        .advance   (ld),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Output stage: load whenever the register is empty or being drained.
    always_comb begin
        state_n = state;
        ld      = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (gnt_valid) begin
                    ld      = 1'b1;
                    state_n = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (gnt_valid) begin
                        ld = 1'b1;
                    end else begin
                        state_n = ST_EMPTY;
                    end
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    // A channel granted this cycle frees its slot, so a fresh trigger
    // on it is captured rather than dropped.
    always_comb begin
        cap_req   = trig & enable;
        granted   = '0;
        capture   = '0;
        drop      = '0;
        pending_n = pending;
        for (int i = 0; i < NUM_CH; i++) begin
            granted[i] = ld && (gnt_idx == CH_ID_WIDTH'(i));
            capture[i] = cap_req[i] && (!pending[i] || granted[i]);
            drop[i]    = cap_req[i] && pending[i] && !granted[i];
            if (capture[i]) begin
                pending_n[i] = 1'b1;
            end else if (granted[i]) begin
                pending_n[i] = 1'b0;
            end
        end
    end

    // Several channels can drop at once; clear and count in one step.
    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ndrop = ndrop + 5'(drop[i]);
        end
        drop_sum     = (overflow_clr ? 17'd0 : {1'b0, drop_count})
                     + 17'(ndrop);
        drop_count_n = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (capture[i]) begin
                hold[i] <= timestamp;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_EMPTY;
            pending       <= '0;
            out_timestamp <= '0;
            out_channel   <= '0;
            overflow      <= '0;
            drop_count    <= '0;
        end else begin
            state      <= state_n;
            pending    <= pending_n;
            overflow   <= (overflow_clr ? '0 : overflow) | drop;
            drop_count <= drop_count_n;
            if (ld) begin
                out_timestamp <= hold[gnt_idx];
                out_channel   <= gnt_idx;
            end
        end
    end

    assign out_valid = (state == ST_FULL);

endmodule : timestamp_capture_arbiter

// File: tb/tb_timestamp_capture_arbiter.sv
// Directed bench for timestamp_capture_arbiter with an expected-output queue.
// Checks reset, latency, round-robin order, backpressure, drops and reset.
module tb_timestamp_capture_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] ts = 64'h100;
    logic [3:0]  trig = '0;
    logic [3:0]  enable = 4'hF;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_timestamp;
    logic [1:0]  out_channel;
    logic [3:0]  overflow;
    logic        overflow_clr = 1'b0;
    logic [15:0] drop_count;

    int total = 0;
    int bad = 0;
    logic [65:0] exp_q [$];

    timestamp_capture_arbiter #(
        .NUM_CH          (4),
        .CH_ID_WIDTH     (2),
        .TIMESTAMP_WIDTH (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .timestamp     (ts),
        .trig          (trig),
        .enable        (enable),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_timestamp (out_timestamp),
        .out_channel   (out_channel),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) ts <= 64'h100;
        else        ts <= ts + 64'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [63:0] v);
        exp_q.push_back({ch, v});
    endtask

    // Handshake completes on the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [65:0] e;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {62'd0, out_channel}, 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                chk("sb_channel", {62'd0, out_channel}, {62'd0, e[65:64]});
                chk("sb_timestamp", out_timestamp, e[63:0]);
            end
        end
    end

    initial begin
        logic [63:0] v;
        int n;

        // Reset state
        #2;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ts", out_timestamp, 64'd0);
        chk("rst_ch", {62'd0, out_channel}, 64'd0);
        chk("rst_ovf", {60'd0, overflow}, 64'd0);
        chk("rst_drop", {48'd0, drop_count}, 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Single capture on ch2 at ts=0x105
        n = 0;
        while (ts != 64'h105 && n < 20) begin
            step();
            n++;
        end
        chk("ts_reach", ts, 64'h105);
        trig = 4'b0100;
        push(2'd2, ts);
        step();
        trig = '0;
        chk("lat_t1", {63'd0, out_valid}, 64'd0);
        step();
        chk("lat_t2", {63'd0, out_valid}, 64'd1);
        chk("lat_ts", out_timestamp, 64'h105);
        chk("lat_ch", {62'd0, out_channel}, 64'd2);
        step();
        chk("lat_done", {63'd0, out_valid}, 64'd0);

        // ch3 alone moves the pointer to 0
        trig = 4'b1000;
        push(2'd3, ts);
        step();
        trig = '0;
        repeat (4) step();

        // All channels at once: order 0,1,2,3 back-to-back
        trig = 4'b1111;
        v = ts;
        for (int i = 0; i < 4; i++) push(2'(i), v);
        step();
        trig = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("rr0_valid", {63'd0, out_valid}, 64'd1);
            chk("rr0_ch", {62'd0, out_channel}, 64'(i));
            step();
        end
        chk("rr0_done", {63'd0, out_valid}, 64'd0);

        // ch1 alone moves the pointer to 2, then order 2,3,0,1
        trig = 4'b0010;
        push(2'd1, ts);
        step();
        trig = '0;
        repeat (4) step();
        trig = 4'b1111;
        v = ts;
        for (int i = 0; i < 4; i++) push(2'((i + 2) % 4), v);
        step();
        trig = '0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("rr2_ch", {62'd0, out_channel}, 64'((i + 2) % 4));
            step();
        end
        chk("rr2_done", {63'd0, out_valid}, 64'd0);

        // Backpressure on ch1 with one drop
        out_ready = 1'b0;
        trig = 4'b0010;
        v = ts;
        push(2'd1, ts);
        step();
        trig = '0;
        step();
        trig = 4'b0010;
        push(2'd1, ts);
        step();
        trig = 4'b0010;
        step();
        trig = '0;
        chk("bp_ovf", {60'd0, overflow}, 64'h2);
        chk("bp_drop", {48'd0, drop_count}, 64'd1);
        repeat (3) step();
        chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold_ts", out_timestamp, v);
        chk("bp_hold_ch", {62'd0, out_channel}, 64'd1);
        out_ready = 1'b1;
        repeat (4) step();
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Clear alone
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("clr_ovf", {60'd0, overflow}, 64'd0);
        chk("clr_drop", {48'd0, drop_count}, 64'd0);

        // Same-cycle regrant on ch0
        trig = 4'b0001;
        push(2'd0, ts);
        step();
        trig = 4'b0001;
        push(2'd0, ts);
        step();
        trig = '0;
        repeat (4) step();
        chk("regrant_ovf", {60'd0, overflow}, 64'd0);
        chk("regrant_drop", {48'd0, drop_count}, 64'd0);
        chk("regrant_drained", 64'(exp_q.size()), 64'd0);

        // Disabled channel ignored
        enable = 4'b0111;
        trig = 4'b1000;
        step();
        trig = '0;
        repeat (3) step();
        chk("dis_valid", {63'd0, out_valid}, 64'd0);
        enable = 4'hF;

        // Clear coincident with a drop: set wins, count becomes 1
        out_ready = 1'b0;
        trig = 4'b0010;
        push(2'd1, ts);
        step();
        trig = '0;
        step();
        trig = 4'b0010;
        push(2'd1, ts);
        step();
        step();
        step();
        trig = '0;
        chk("pre_clr_drop", {48'd0, drop_count}, 64'd2);
        trig = 4'b0010;
        overflow_clr = 1'b1;
        step();
        trig = '0;
        overflow_clr = 1'b0;
        chk("clrset_ovf", {60'd0, overflow}, 64'h2);
        chk("clrset_drop", {48'd0, drop_count}, 64'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("clr2_ovf", {60'd0, overflow}, 64'd0);
        out_ready = 1'b1;
        repeat (4) step();
        chk("clr_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream with output full and pending=1010
        out_ready = 1'b0;
        trig = 4'b0010;
        push(2'd1, ts);
        step();
        trig = '0;
        step();
        trig = 4'b1010;
        push(2'd1, ts);
        push(2'd3, ts);
        step();
        trig = '0;
        chk("mid_valid", {63'd0, out_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ts", out_timestamp, 64'd0);
        chk("mid_rst_ch", {62'd0, out_channel}, 64'd0);
        chk("mid_rst_ovf", {60'd0, overflow}, 64'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
        end
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_timestamp_capture_arbiter
